mul_seq_32: RTL and testbench



---
 rtl/mul_seq_32_if.sv | 18 +
 rtl/mul_seq_32.sv | 121 ++++++++++++
 tb/tb_mul_seq_32.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_32_if.sv
// Operand/result bus between the execute-stage operand mux and mul_seq_32.
// master drives the request side, slave (the multiplier) drives the result side.
interface mul_seq_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Ctrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             overflow;

  modport master (output start, A, B, Ctrl, input busy, done, Hi, Lo, overflow);
  modport slave  (input start, A, B, Ctrl, output busy, done, Hi, Lo, overflow);
endinterface

// File: rtl/mul_seq_32.sv
// Sequential signed 32x32 multiplier: radix-2 shift-add on operand magnitudes
// for WIDTH cycles, then one sign-fix cycle producing {Hi,Lo} and overflow.
module mul_seq_32 #(
  parameter int         WIDTH  = 32,
  parameter logic [2:0] MUL_OP = 3'b100
) (
  input  logic         clk,
  input  logic         reset,
  mul_seq_32_if.slave  bus
);

  localparam int            CW         = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  // |0x80000000| wraps back to 0x80000000, which is correct when read unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  state_t             state_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               neg_r;
  logic [CW-1:0]      count_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               ovf_r;

  logic               start_ok_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_shift_s;
  logic [2*WIDTH-1:0] result_s;
  logic               ovf_s;

  // Next-iteration accumulator, sign-fixed result and its overflow.
  always_comb begin
    start_ok_s = bus.start && (bus.Ctrl == MUL_OP);
    if (acc_r[0]) begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    // The add carry lands in bit 63 as the whole accumulator shifts right.
    acc_shift_s = {sum_s, acc_r[WIDTH-1:1]};
    if (neg_r) begin
      result_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result_s = acc_r;
    end
    ovf_s = (result_s[2*WIDTH-1:WIDTH] != {WIDTH{result_s[WIDTH-1]}});
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      mcand_r <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      neg_r   <= 1'b0;
      count_r <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_ok_s) begin
            mcand_r <= magnitude(bus.A);
            acc_r   <= {{WIDTH{1'b0}}, magnitude(bus.B)};
            neg_r   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          acc_r   <= acc_shift_s;
          count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          if (count_r == LAST_COUNT) begin
            state_r <= SIGN;
          end
        end
        SIGN: begin
          hi_r    <= result_s[2*WIDTH-1:WIDTH];
          lo_r    <= result_s[WIDTH-1:0];
          ovf_r   <= ovf_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.Hi       = hi_r;
  assign bus.Lo       = lo_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32: expected products are queued when an
// operation is issued and popped when done is seen.
module tb_mul_seq_32;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t q[$];

  mul_seq_32_if bus ();

  mul_seq_32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    exp_t   r;
    p     = longint'($signed(a)) * longint'($signed(b));
    r.hi  = p[63:32];
    r.lo  = p[31:0];
    r.ovf = (p[63:32] != {32{p[31]}});
    return r;
  endfunction

  // Drive one start pulse; returns just after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl, input bit push);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.Ctrl  = ctrl;
    bus.start = 1'b1;
    if (push) q.push_back(model(a, b));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Returns the index of the edge after which done was first seen, or -1.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        edges = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.A = 32'd0; bus.B = 32'd0; bus.Ctrl = 3'b000;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.Hi, bus.Lo, bus.overflow} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b Hi=%h Lo=%h ovf=%b, want all 0",
               bus.busy, bus.done, bus.Hi, bus.Lo, bus.overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    exp_t e;
    issue(32'd3, 32'd5, 3'b100, 1'b1);
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      n_checks++;
      if (k < 33 && {bus.busy, bus.done} !== 2'b10) begin
        n_fail++;
        $display("FAIL basic_busy edge %0d: got busy=%b done=%b, want busy=1 done=0", k, bus.busy, bus.done);
      end else if (k == 33 && {bus.busy, bus.done} !== 2'b01) begin
        n_fail++;
        $display("FAIL basic_done edge 33: got busy=%b done=%b, want busy=0 done=1", bus.busy, bus.done);
      end
    end
    e = q.pop_front();
    n_checks++;
    if ({bus.Hi, bus.Lo, bus.overflow} !== e) begin
      n_fail++;
      $display("FAIL basic_result: got %h/%h/%b, want %h/%h/%b", bus.Hi, bus.Lo, bus.overflow, e.hi, e.lo, e.ovf);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got done=%b one cycle later, want 0", bus.done);
    end
  endtask

  task automatic test_signed;
    logic [31:0] av[5] = '{32'hFFFFFFFE, 32'h00010000, 32'h80000000, 32'h00000000, 32'h7FFFFFFF};
    logic [31:0] bv[5] = '{32'd7,        32'h00010000, 32'h80000000, 32'h12345678, 32'h80000000};
    int   edges;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(av[i], bv[i], 3'b100, 1'b1);
      wait_done(edges);
      n_checks++;
      if (edges !== 33) begin
        n_fail++;
        $display("FAIL signed_latency[%0d]: got %0d edges, want 33", i, edges);
      end
      e = q.pop_front();
      n_checks++;
      if ({bus.Hi, bus.Lo, bus.overflow} !== e) begin
        n_fail++;
        $display("FAIL signed_result[%0d]: got %h/%h/%b, want %h/%h/%b",
                 i, bus.Hi, bus.Lo, bus.overflow, e.hi, e.lo, e.ovf);
      end
    end
  endtask

  task automatic test_ignore;
    int   k;
    int   extra;
    exp_t e;
    issue(32'd100, 32'hFFFFFFFD, 3'b100, 1'b1);
    k = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.A = 32'd9; bus.B = 32'd9; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        k = i;
        break;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (k !== 33) begin
      n_fail++;
      $display("FAIL ignore_busy_latency: got done at edge %0d, want 33", k);
    end
    e = q.pop_front();
    n_checks++;
    if ({bus.Hi, bus.Lo, bus.overflow} !== e) begin
      n_fail++;
      $display("FAIL ignore_busy_result: got %h/%h/%b, want %h/%h/%b", bus.Hi, bus.Lo, bus.overflow, e.hi, e.lo, e.ovf);
    end
    issue(32'd9, 32'd9, 3'b011, 1'b0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL ignore_activity: got %0d cycles with busy/done, want 0", extra);
    end
    n_checks++;
    if ({bus.Hi, bus.Lo, bus.overflow} !== e) begin
      n_fail++;
      $display("FAIL ignore_hold: got %h/%h/%b, want %h/%h/%b", bus.Hi, bus.Lo, bus.overflow, e.hi, e.lo, e.ovf);
    end
  endtask

  task automatic test_reset_mid;
    int   extra;
    int   edges;
    exp_t e;
    issue(32'd7, 32'd8, 3'b100, 1'b0);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.Hi, bus.Lo, bus.overflow} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b Hi=%h Lo=%h ovf=%b, want all 0",
               bus.busy, bus.done, bus.Hi, bus.Lo, bus.overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d active cycles after reset, want 0", extra);
    end
    issue(32'd4, 32'd4, 3'b100, 1'b1);
    wait_done(edges);
    e = q.pop_front();
    n_checks++;
    if (edges !== 33 || {bus.Hi, bus.Lo, bus.overflow} !== e) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got edge %0d %h/%h/%b, want edge 33 %h/%h/%b",
               edges, bus.Hi, bus.Lo, bus.overflow, e.hi, e.lo, e.ovf);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e1;
    exp_t e2;
    int   held_bad;
    int   d2;
    @(negedge clk);
    bus.A = 32'hFFFF0000; bus.B = 32'd3; bus.Ctrl = 3'b100; bus.start = 1'b1;
    q.push_back(model(32'hFFFF0000, 32'd3));
    @(posedge clk);
    #1;
    bus.A = 32'd12345; bus.B = 32'hFFFFFFF9;
    q.push_back(model(32'd12345, 32'hFFFFFFF9));
    held_bad = 0;
    d2 = -1;
    for (int k = 0; k <= 80; k++) begin
      @(negedge clk);
      if (k == 33) begin
        e1 = q.pop_front();
        n_checks++;
        if (bus.done !== 1'b1 || {bus.Hi, bus.Lo, bus.overflow} !== e1) begin
          n_fail++;
          $display("FAIL b2b_first: got done=%b %h/%h/%b, want done=1 %h/%h/%b",
                   bus.done, bus.Hi, bus.Lo, bus.overflow, e1.hi, e1.lo, e1.ovf);
        end
      end else if (k == 34) begin
        bus.start = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
          n_fail++;
          $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
        end
      end else if (k > 34 && bus.done === 1'b1) begin
        d2 = k;
        break;
      end else if (k > 34 && {bus.Hi, bus.Lo, bus.overflow} !== e1) begin
        held_bad++;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (held_bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_hold: got %0d cycles where first result changed, want 0", held_bad);
    end
    e2 = q.pop_front();
    n_checks++;
    if (d2 !== 67 || {bus.Hi, bus.Lo, bus.overflow} !== e2) begin
      n_fail++;
      $display("FAIL b2b_second: got edge %0d %h/%h/%b, want edge 67 %h/%h/%b",
               d2, bus.Hi, bus.Lo, bus.overflow, e2.hi, e2.lo, e2.ovf);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_signed();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
